serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two W-bit operands five bits per cycle, LSB slice
// first, then presents {carry, sum} with a one-cycle done pulse.
// Carry-in comes from a kill/generate code; an illegal code sets err with done.
module serial_add_ctrl #(
  parameter int unsigned NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [5*NSLICE-1:0]   a,
  input  logic [5*NSLICE-1:0]   b,
  input  logic [1:0]            k_in,
  output logic                  busy,
  output logic                  done,
  output logic [5*NSLICE:0]     sum,
  output logic                  err
);

  localparam int unsigned W    = 5 * NSLICE;
  localparam int unsigned IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W:0]      sum_q, sum_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            err_pending_q, err_pending_d;

  logic            accept;
  logic [4:0]      a_slice;
  logic [4:0]      b_slice;
  logic [5:0]      slice_sum;

  // A new request is taken only when no addition is in flight.
  assign accept = start && (state_q != S_RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> (RUN | IDLE).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    err  = (state_q == S_DONE) && err_pending_q;
  end

  // Slice adder: current 5-bit slices of both operands plus running carry.
  always_comb begin
    a_slice   = a_q[5*int'(idx_q) +: 5];
    b_slice   = b_q[5*int'(idx_q) +: 5];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {5'b0, carry_q};
  end

  // Datapath next values: capture on accept, one slice per RUN cycle,
  // result published on the same edge that writes the last slice.
  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    acc_d         = acc_q;
    sum_d         = sum_q;
    idx_d         = idx_q;
    carry_d       = carry_q;
    err_pending_d = err_pending_q;
    if (accept) begin
      a_d           = a;
      b_d           = b;
      acc_d         = '0;
      idx_d         = '0;
      carry_d       = (k_in == 2'b11);
      err_pending_d = k_in[1] ^ k_in[0];
    end else if (state_q == S_RUN) begin
      acc_d[5*int'(idx_q) +: 5] = slice_sum[4:0];
      carry_d                   = slice_sum[5];
      if (idx_q == LAST_IDX) begin
        sum_d = {slice_sum[5], acc_d};
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      err_pending_q <= 1'b0;
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      sum_q         <= sum_d;
      idx_q         <= idx_d;
      carry_q       <= carry_d;
      err_pending_q <= err_pending_d;
    end
  end

  assign sum = sum_q;

endmodule
